// File: rtl/add_num_pkg.sv
// Shared types, result-line layout and accumulator identity for the reduce engine.
package add_num_pkg;

  localparam int LINE_W    = 512;
  localparam int ADDR_W    = 42;
  localparam int ACC_LSB   = 0;
  localparam int COUNT_LSB = 64;
  localparam int OP_LSB    = 128;
  localparam int ERR_BIT   = 510;
  localparam int DONE_BIT  = 511;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    DRAIN    = 3'd2,
    WRITE    = 3'd3,
    WAIT_ACK = 3'd4
  } t_state;

  typedef enum logic [1:0] {
    OP_SUM  = 2'd0,
    OP_MAX  = 2'd1,
    OP_MIN  = 2'd2,
    OP_RSVD = 2'd3
  } t_op;

  // Neutral starting value of the reduction, expressed in the low acc_w bits.
  function automatic logic [63:0] add_num_identity(t_op op, int acc_w, bit is_signed);
    logic [63:0] ones;
    logic [63:0] msb;
    ones = (acc_w >= 64) ? '1 : ((64'd1 << acc_w) - 64'd1);
    msb  = 64'd1 << (acc_w - 1);
    case (op)
      OP_MAX:  return is_signed ? msb : 64'd0;
      OP_MIN:  return is_signed ? (msb - 64'd1) : ones;
      default: return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/add_num_reduce_engine_line_reduce.sv
// Stage 1 of the reduce pipeline: folds all lanes of one line into a single registered value.
module add_num_line_reduce
  import add_num_pkg::*;
#(
  parameter int ELEM_W = 8,
  parameter int ACC_W  = 64,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [511:0]      in_data,
  input  t_op               in_op,
  output logic              vld_p1,
  output logic [ACC_W-1:0]  val_p1
);

  localparam int LANES = 512 / ELEM_W;

  logic             vld_p1_d, vld_p1_q;
  logic [ACC_W-1:0] red_p1_d, red_p1_q;

  function automatic logic [ACC_W-1:0] combine(logic [ACC_W-1:0] a, logic [ACC_W-1:0] b, t_op o);
    logic b_gt;
    b_gt = (SIGNED != 0) ? ($signed(b) > $signed(a)) : (b > a);
    case (o)
      OP_SUM:  return a + b;
      OP_MAX:  return b_gt ? b : a;
      OP_MIN:  return (b_gt || (b == a)) ? a : b;
      default: return a;
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] extend(logic [ELEM_W-1:0] e);
    return (SIGNED != 0) ? ACC_W'($signed(e)) : ACC_W'(e);
  endfunction

  always_comb begin
    vld_p1_d = in_vld;
    red_p1_d = ACC_W'(add_num_identity(in_op, ACC_W, SIGNED != 0));
    for (int i = 0; i < LANES; i++) begin
      red_p1_d = combine(red_p1_d, extend(in_data[i*ELEM_W +: ELEM_W]), in_op);
    end
  end

  // stage 1 boundary: reduced line value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    if (in_vld) red_p1_q <= red_p1_d;
  end

  assign vld_p1 = vld_p1_q;
  assign val_p1 = red_p1_q;

endmodule

// File: rtl/add_num_reduce_engine.sv
// Streams num_lines source lines, reduces every element (sum/max/min) and writes one result line.
module add_num_reduce_engine
  import add_num_pkg::*;
#(
  parameter int ELEM_W          = 8,
  parameter int ACC_W           = 64,
  parameter int SIGNED          = 0,
  parameter int MAX_OUTSTANDING = 16,
  parameter int LEN_W           = 16,
  localparam int TAG_W          = $clog2(MAX_OUTSTANDING)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [41:0]        src_addr,
  input  logic [41:0]        dst_addr,
  input  logic [LEN_W-1:0]   num_lines,
  input  logic [1:0]         op,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               rd_req_valid,
  output logic [41:0]        rd_req_addr,
  output logic [TAG_W-1:0]   rd_req_tag,
  input  logic               rd_almfull,
  input  logic               rd_rsp_valid,
  input  logic [TAG_W-1:0]   rd_rsp_tag,
  input  logic [511:0]       rd_rsp_data,
  output logic               wr_req_valid,
  output logic [41:0]        wr_req_addr,
  output logic [511:0]       wr_req_data,
  input  logic               wr_almfull,
  input  logic               wr_rsp_valid
);

  localparam int OUT_W = TAG_W + 1;

  t_state             state_d, state_q;
  logic [LEN_W-1:0]   iss_d, iss_q, rsp_d, rsp_q, num_d, num_q;
  logic [OUT_W-1:0]   out_d, out_q;
  logic [ACC_W-1:0]   acc_d, acc_q;
  logic               err_d, err_q, done_d, done_q;
  logic [41:0]        src_d, src_q, dst_d, dst_q;
  t_op                op_d, op_q;
  logic               rd_issue, rsp_accept, wr_fire;
  logic               red_vld_p1;
  logic [ACC_W-1:0]   red_val_p1;
  logic [511:0]       line;
  logic               unused_tag;

  // Tags are informational only: the reduction does not care about order.
  assign unused_tag = ^rd_rsp_tag;

  function automatic logic [ACC_W-1:0] acc_combine(logic [ACC_W-1:0] a, logic [ACC_W-1:0] b, t_op o);
    logic b_gt;
    b_gt = (SIGNED != 0) ? ($signed(b) > $signed(a)) : (b > a);
    case (o)
      OP_SUM:  return a + b;
      OP_MAX:  return b_gt ? b : a;
      OP_MIN:  return (b_gt || (b == a)) ? a : b;
      default: return a;
    endcase
  endfunction

  assign rd_issue   = (state_q == READ) && !rd_almfull && (out_q < OUT_W'(MAX_OUTSTANDING));
  assign rsp_accept = rd_rsp_valid && ((state_q == READ) || (state_q == DRAIN));
  assign wr_fire    = (state_q == WRITE) && !wr_almfull;

  add_num_line_reduce #(
    .ELEM_W (ELEM_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_line_reduce (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (rsp_accept),
    .in_data (rd_rsp_data),
    .in_op   (op_q),
    .vld_p1  (red_vld_p1),
    .val_p1  (red_val_p1)
  );

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    rsp_d   = rsp_q;
    out_d   = out_q;
    acc_d   = acc_q;
    err_d   = err_q;
    done_d  = 1'b0;
    src_d   = src_q;
    dst_d   = dst_q;
    num_d   = num_q;
    op_d    = op_q;

    if (rd_issue)   iss_d = iss_q + LEN_W'(1);
    if (rsp_accept) rsp_d = rsp_q + LEN_W'(1);
    case ({rd_issue, rsp_accept})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase
    if (red_vld_p1) acc_d = acc_combine(acc_q, red_val_p1, op_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          num_d = num_lines;
          op_d  = t_op'(op);
          iss_d = '0;
          rsp_d = '0;
          out_d = '0;
          err_d = (op == 2'd3);
          acc_d = (op == 2'd3) ? '0 : ACC_W'(add_num_identity(t_op'(op), ACC_W, SIGNED != 0));
          if ((op == 2'd3) || (num_lines == '0)) state_d = WRITE;
          else                                   state_d = READ;
        end
      end
      READ:     if (rd_issue && (iss_q + LEN_W'(1) == num_q)) state_d = DRAIN;
      // The stage-1 register must be empty so the last line has reached acc.
      DRAIN:    if ((rsp_q == num_q) && !red_vld_p1) state_d = WRITE;
      WRITE:    if (wr_fire) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (wr_rsp_valid) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // stage 2 boundary: accumulator and control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      iss_q   <= '0;
      rsp_q   <= '0;
      out_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      rsp_q   <= rsp_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    src_q <= src_d;
    dst_q <= dst_d;
    num_q <= num_d;
    op_q  <= op_d;
  end

  always_comb begin
    line                     = '0;
    line[ACC_LSB +: 64]      = 64'(acc_q);
    line[COUNT_LSB +: 64]    = 64'(rsp_q);
    line[OP_LSB +: 2]        = op_q;
    line[ERR_BIT]            = err_q;
    line[DONE_BIT]           = 1'b1;
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign rd_req_valid = rd_issue;
  assign rd_req_addr  = rd_issue ? (src_q + 42'(iss_q)) : '0;
  assign rd_req_tag   = rd_issue ? iss_q[TAG_W-1:0] : '0;
  assign wr_req_valid = wr_fire;
  assign wr_req_addr  = wr_fire ? dst_q : '0;
  assign wr_req_data  = wr_fire ? line : '0;

endmodule
